pipe_adder: RTL and testbench

//   Parametrised, pipelined adder/subtractor for the ALU datapath; next generation of the single-stage adder.

---
 rtl/pipe_adder_pkg.sv | 20 ++
 rtl/pipe_adder_chunk.sv | 27 ++
 rtl/pipe_adder.sv | 119 +++++++++++
 tb/tb_pipe_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared ALU datapath constants and helpers for the pipelined adder.
// Latency: none (definitions only).
// Backpressure: not applicable.
package pipe_adder_pkg;

    // Default datapath width of the ALU operands.
    localparam int ALU_WIDTH = 32;

    // Operation select carried on the sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Two's-complement overflow: both addends share a sign the result lost.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipe_adder_chunk.sv
// One CHUNK-bit ripple slice of the pipelined adder with registered sum and carry.
// Latency: 1 cycle from a/b/cin to s/cout.
// Backpressure: holds s/cout whenever en is low.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    // Register the slice sum and its carry-out; hold when the pipe is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else if (en) begin
            {cout, s} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chained slices, with ovf/zero flags.
// Latency: STAGES cycles from an accepted beat to out_valid; one beat per cycle.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready drops with it.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic advance;

    // Values presented to slice k: stage 0 is the conditioned input beat,
    // later stages come from the skew registers.
    logic [WIDTH-1:0] a_st [STAGES];
    logic [WIDTH-1:0] b_st [STAGES];
    logic [WIDTH-1:0] r_st [STAGES];
    logic [STAGES-1:0] c_st;
    logic [STAGES-1:0] v_st;

    // Skew registers between stages: operands ride along until their chunk
    // is added; r_q carries the already finished lower result chunks.
    logic [WIDTH-1:0] a_q [1:STAGES];
    logic [WIDTH-1:0] b_q [1:STAGES];
    logic [WIDTH-1:0] r_q [1:STAGES];
    logic [STAGES:1]  v_q;

    // Result view per stage: finished lower chunks merged with the slice output just registered.
    logic [WIDTH-1:0] rv [1:STAGES];

    logic [STAGES-1:0][CHUNK-1:0] chunk_s;
    logic [STAGES-1:0]            chunk_c;

    assign advance  = !v_q[STAGES] || out_ready;
    assign in_ready = advance;

    // Build the per-slice operand, carry and partial-result views.
    always_comb begin
        a_st[0] = a;
        b_st[0] = (sub == OP_SUB) ? ~b : b;
        c_st[0] = (sub == OP_SUB) ? ~cin : cin;
        v_st[0] = in_valid;
        r_st[0] = '0;
        for (int k = 1; k <= STAGES; k++) begin
            rv[k] = r_q[k];
            rv[k][(k-1)*CHUNK +: CHUNK] = chunk_s[k-1];
        end
        for (int k = 1; k < STAGES; k++) begin
            a_st[k] = a_q[k];
            b_st[k] = b_q[k];
            c_st[k] = chunk_c[k-1];
            v_st[k] = v_q[k];
            r_st[k] = rv[k];
        end
    end

    // Advance the skew/de-skew registers and the valid pipe together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            v_q <= '0;
        end else if (advance) begin
            for (int k = 1; k <= STAGES; k++) begin
                a_q[k] <= a_st[k-1];
                b_q[k] <= b_st[k-1];
                r_q[k] <= r_st[k-1];
            end
            v_q <= v_st;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_chunk #(
            .W(CHUNK)
        ) u_chunk (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .a   (a_st[k][k*CHUNK +: CHUNK]),
            .b   (b_st[k][k*CHUNK +: CHUNK]),
            .cin (c_st[k]),
            .s   (chunk_s[k]),
            .cout(chunk_c[k])
        );
    end

    // Final stage outputs; zero is qualified by valid so an empty pipe reports 0.
    assign out_valid = v_q[STAGES];
    assign s         = rv[STAGES];
    assign cout      = chunk_c[STAGES-1];
    assign ovf       = signed_ovf(a_q[STAGES][WIDTH-1], b_q[STAGES][WIDTH-1], rv[STAGES][WIDTH-1]);
    assign zero      = v_q[STAGES] && !(|rv[STAGES]);

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder at STAGES = 4, 1 and 8 driven by one shared stimulus stream.
// Latency: scoreboard expects exactly STAGES cycles when the checker is enabled.
// Backpressure: out_ready is stalled and randomised; held outputs must stay stable.
module tb_pipe_adder;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic cin = 1'b0;
    logic sub = 1'b0;

    logic [2:0]       in_ready_w;
    logic [2:0]       out_valid_w;
    logic [2:0]       cout_w;
    logic [2:0]       ovf_w;
    logic [2:0]       zero_w;
    logic [2:0][31:0] s_w;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int pend [3];
    bit lat_chk = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model written directly from the arithmetic definition.
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic sb);
        exp_t e;
        logic [32:0] full;
        if (!sb) begin
            full   = {1'b0, av} + {1'b0, bv} + {32'b0, ci};
            e.cout = full[32];
            e.ovf  = (av[31] == bv[31]) && (full[31] != av[31]);
        end else begin
            full   = {1'b0, av} - {1'b0, bv} - {32'b0, ci};
            e.cout = ~full[32];
            e.ovf  = (av[31] != bv[31]) && (full[31] != av[31]);
        end
        e.s    = full[31:0];
        e.zero = (full[31:0] == 32'd0);
        e.cyc  = 0;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

        pipe_adder #(
            .WIDTH (32),
            .STAGES(ST)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready_w[g]),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid_w[g]),
            .out_ready(out_ready),
            .s        (s_w[g]),
            .cout     (cout_w[g]),
            .ovf      (ovf_w[g]),
            .zero     (zero_w[g])
        );

        exp_t q [$];
        exp_t e;
        logic hold_p = 1'b0;
        logic [31:0] s_p;
        logic [2:0] f_p;

        // Scoreboard monitor sampled on the falling edge.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                pend[g] = 0;
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    chk($sformatf("stable_s_st%0d", ST), s_w[g], s_p);
                    chk($sformatf("stable_flags_st%0d", ST), {cout_w[g], ovf_w[g], zero_w[g]}, f_p);
                end
                if (out_valid_w[g] && out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("unexpected_beat_st%0d", ST), out_valid_w[g], 1'b0);
                    end else begin
                        e = q.pop_front();
                        pend[g]--;
                        chk($sformatf("s_st%0d", ST), s_w[g], e.s);
                        chk($sformatf("cout_st%0d", ST), cout_w[g], e.cout);
                        chk($sformatf("ovf_st%0d", ST), ovf_w[g], e.ovf);
                        chk($sformatf("zero_st%0d", ST), zero_w[g], e.zero);
                        if (lat_chk) chk($sformatf("latency_st%0d", ST), ncyc - e.cyc, ST);
                    end
                end
                if (in_valid && in_ready_w[g]) begin
                    e = model(a, b, cin, sub);
                    e.cyc = ncyc;
                    q.push_back(e);
                    pend[g]++;
                end
                hold_p = out_valid_w[g] && !out_ready;
                s_p = s_w[g];
                f_p = {cout_w[g], ovf_w[g], zero_w[g]};
            end
        end
    end

    // Present one beat and wait until the STAGES=4 instance takes it.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
        bit acc;
        acc = 1'b0;
        a = av;
        b = bv;
        cin = ci;
        sub = sb;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready_w[0];
            @(posedge clk);
            #1;
            if (!acc) out_ready = 1'b1;
        end
        chk("accept", acc, 1'b1);
    endtask

    task automatic drain();
        int sum;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sum = 1;
        for (int t = 0; t < 60 && sum != 0; t++) begin
            @(posedge clk);
            #1;
            sum = pend[0] + pend[1] + pend[2];
        end
        chk("drain", sum, 0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_valid%0d", tag, g), out_valid_w[g], 1'b0);
            chk($sformatf("%s_s%0d", tag, g), s_w[g], 32'd0);
            chk($sformatf("%s_flags%0d", tag, g), {cout_w[g], ovf_w[g], zero_w[g]}, 3'b000);
        end
    endtask

    initial begin
        pend[0] = 0;
        pend[1] = 0;
        pend[2] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Signed overflow into the sign bit.
        @(posedge clk);
        #1;
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        drain();

        // All-ones plus carry-in wraps to zero.
        send(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        drain();

        // Subtract with borrow, then a negative-to-positive overflow.
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        drain();

        // Back-to-back stream.
        for (int i = 1; i <= 8; i++) send(i, i, 1'b0, 1'b0);
        drain();

        // Same stream with a 3-cycle downstream stall mid-stream.
        lat_chk = 1'b0;
        for (int i = 1; i <= 5; i++) send(i, i, 1'b0, 1'b0);
        a = 32'd6;
        b = 32'd6;
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready_w[0], 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 6; i <= 8; i++) send(i, i, 1'b0, 1'b0);
        drain();
        lat_chk = 1'b1;

        // Reset with beats in flight: nothing stale may come out afterwards.
        for (int i = 1; i <= 3; i++) send(32'h100 * i, 32'd3, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("inflight_rst");
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_pending", pend[0] + pend[1] + pend[2], 0);

        // Reset during a stall.
        send(32'd9, 32'd9, 1'b0, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state("stall_rst");

        // Random operands with random downstream back-pressure.
        lat_chk = 1'b0;
        for (int i = 0; i < 24; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
